bram_result_checker: RTL and testbench

Synthesisable, parametrised golden-compare engine for the CNN accelerator's on-chip self test. After the `cnn` core raises `done`, this block sweeps a result BRAM and a golden BRAM word by word over two read-only BRAM-style ports. It reports pass/fail, a saturating mismatch count and the first mismatch (index, got, expected). It moves the testbench's post-run DM-vs-GOLDEN check into hardware, generalised in word count, width, read latency, base address, compare mask and stop-on-first mode.

---
 rtl/cnn_pkg.sv | 7 +
 rtl/rd_lat_pipe.sv | 43 ++++
 rtl/bram_result_checker.sv | 122 ++++++++++++
 tb/tb_bram_result_checker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: types and constants shared by the CNN accelerator blocks.
package cnn_pkg;
    localparam int CNN_DATA_W = 32;
    localparam int CNN_ADDR_W = 32;
    localparam logic [3:0] BRAM_WE_NONE = 4'b0;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} chk_state_t;
endpackage

// File: rtl/rd_lat_pipe.sv
// rd_lat_pipe: valid+index delay line matching the BRAM read latency, with flush.
module rd_lat_pipe
    import cnn_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int IDX_W = CNN_ADDR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [IDX_W-1:0] push_idx,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             empty
);
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0][IDX_W-1:0] idx_q, idx_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_st
        if (i == 0) begin : g_h
            assign vld_d[i] = push & ~flush;
            assign idx_d[i] = push_idx;
        end else begin : g_t
            assign vld_d[i] = vld_q[i-1] & ~flush;
            assign idx_d[i] = idx_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_idx = idx_q[DEPTH-1];
    assign empty   = ~|vld_q;
endmodule

// File: rtl/bram_result_checker.sv
// bram_result_checker: sweeps result and golden BRAMs, counts masked mismatches
// and captures the first one.
module bram_result_checker
    import cnn_pkg::*;
#(
    parameter int                DATA_W      = CNN_DATA_W,
    parameter int                ADDR_W      = CNN_ADDR_W,
    parameter int                N_WORDS     = 100,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(1),
    parameter int                RD_LAT      = 1,
    parameter int                ERR_W       = 16,
    parameter logic [DATA_W-1:0] CMP_MASK    = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop_on_first,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp,
    output logic              res_en,
    output logic [ADDR_W-1:0] res_addr,
    output logic [3:0]        res_we,
    input  logic [DATA_W-1:0] res_dout,
    output logic              gold_en,
    output logic [ADDR_W-1:0] gold_addr,
    output logic [3:0]        gold_we,
    input  logic [DATA_W-1:0] gold_dout
);
    if (N_WORDS < 1) begin : g_bad_n
        $error("N_WORDS must be at least 1");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("RD_LAT must be in 1..4");
    end

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

    chk_state_t        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d, fidx_q, fidx_d, cmp_idx, addr;
    logic [DATA_W-1:0] fgot_q, fgot_d, fexp_q, fexp_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              sof_q, sof_d;
    logic              cmp_vld, empty, mism, stop, accept, issuing;

    assign accept  = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign issuing = state_q == ST_RUN;
    assign mism    = cmp_vld && ((res_dout ^ gold_dout) & CMP_MASK) != '0;
    // A stop-on-first hit flushes the pipe so later in-flight words are never counted.
    assign stop    = mism && sof_q;

    rd_lat_pipe #(.DEPTH(RD_LAT), .IDX_W(ADDR_W)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .flush    (stop || accept),
        .push     (issuing),
        .push_idx (idx_q),
        .out_vld  (cmp_vld),
        .out_idx  (cmp_idx),
        .empty    (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            sof_q   <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fgot_q  <= '0;
            fexp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sof_q   <= sof_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fgot_q  <= fgot_d;
            fexp_q  <= fexp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: state_d = start ? ST_RUN : state_q;
            ST_RUN:           state_d = (stop || idx_q == LAST) ? ST_DRAIN : ST_RUN;
            ST_DRAIN:         state_d = empty ? ST_DONE : ST_DRAIN;
        endcase
    end

    always_comb begin
        idx_d  = accept ? '0 : issuing ? idx_q + ADDR_W'(1) : idx_q;
        sof_d  = accept ? stop_on_first : sof_q;
        err_d  = accept ? '0 : (mism && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
        fidx_d = accept ? '0 : (mism && err_q == '0) ? cmp_idx : fidx_q;
        fgot_d = accept ? '0 : (mism && err_q == '0) ? res_dout : fgot_q;
        fexp_d = accept ? '0 : (mism && err_q == '0) ? gold_dout : fexp_q;
    end

    always_comb begin
        addr          = issuing ? BASE_ADDR + idx_q * ADDR_STRIDE : '0;
        busy          = state_q == ST_RUN || state_q == ST_DRAIN;
        done          = state_q == ST_DONE;
        pass          = state_q == ST_DONE && err_q == '0;
        res_en        = issuing;
        gold_en       = issuing;
        res_addr      = addr;
        gold_addr     = addr;
        res_we        = BRAM_WE_NONE;
        gold_we       = BRAM_WE_NONE;
        err_cnt       = err_q;
        first_err_idx = fidx_q;
        first_err_got = fgot_q;
        first_err_exp = fexp_q;
    end
endmodule

// File: tb/tb_bram_result_checker.sv
// tb_bram_result_checker: randomized sweeps on three configurations checked
// against a word-list reference model.
module tb_bram_result_checker;
    typedef struct {
        int          done_edge;
        int          en_cnt;
        logic [31:0] max_addr;
        bit          overlap;
        bit          addr_neq;
        logic        pass;
        logic [31:0] err;
        logic [31:0] fidx;
        logic [31:0] fgot;
        logic [31:0] fexp;
    } obs_t;

    localparam int          NW  [3] = '{100, 100, 20};
    localparam int          LAT [3] = '{1, 3, 2};
    localparam int          SAT [3] = '{65535, 65535, 3};
    localparam logic [31:0] MSK [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
    localparam logic [31:0] BAS [3] = '{32'h0, 32'h100, 32'h0};
    localparam logic [31:0] STR [3] = '{32'd1, 32'd4, 32'd1};

    logic clk = 0, rst = 1;
    logic [2:0] start = '0, sof = '0, busy, done, pass, res_en, gold_en;
    logic [2:0][31:0] res_addr, gold_addr, res_dout, gold_dout, fidx, fgot, fexp;
    logic [5:0][3:0] we;
    logic [15:0] err0, err1;
    logic [1:0]  err2;
    logic [31:0] res_mem [100], gold_mem [100];
    logic [31:0] r0, g0, r1 [3], g1 [3], r2 [2], g2 [2];
    int cyc = 0, total = 0, bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_result_checker u0 (
        .clk(clk), .rst(rst), .start(start[0]), .stop_on_first(sof[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .err_cnt(err0), .first_err_idx(fidx[0]),
        .first_err_got(fgot[0]), .first_err_exp(fexp[0]), .res_en(res_en[0]),
        .res_addr(res_addr[0]), .res_we(we[0]), .res_dout(res_dout[0]), .gold_en(gold_en[0]),
        .gold_addr(gold_addr[0]), .gold_we(we[1]), .gold_dout(gold_dout[0]));

    bram_result_checker #(.RD_LAT(3), .BASE_ADDR(32'h100), .ADDR_STRIDE(32'd4)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .stop_on_first(sof[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .err_cnt(err1), .first_err_idx(fidx[1]),
        .first_err_got(fgot[1]), .first_err_exp(fexp[1]), .res_en(res_en[1]),
        .res_addr(res_addr[1]), .res_we(we[2]), .res_dout(res_dout[1]), .gold_en(gold_en[1]),
        .gold_addr(gold_addr[1]), .gold_we(we[3]), .gold_dout(gold_dout[1]));

    bram_result_checker #(.N_WORDS(20), .RD_LAT(2), .ERR_W(2), .CMP_MASK(32'hFFFF_FFF0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]), .stop_on_first(sof[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .err_cnt(err2), .first_err_idx(fidx[2]),
        .first_err_got(fgot[2]), .first_err_exp(fexp[2]), .res_en(res_en[2]),
        .res_addr(res_addr[2]), .res_we(we[4]), .res_dout(res_dout[2]), .gold_en(gold_en[2]),
        .gold_addr(gold_addr[2]), .gold_we(we[5]), .gold_dout(gold_dout[2]));

    function automatic int widx(input logic [31:0] a, input int d);
        logic [31:0] w = (a - BAS[d]) / STR[d];
        return (w < 32'd100) ? int'(w) : 0;
    endfunction

    // Behavioural BRAMs: address sampled on the edge, data out RD_LAT edges later.
    always @(posedge clk) begin
        if (res_en[0])  r0 <= res_mem[widx(res_addr[0], 0)];
        if (gold_en[0]) g0 <= gold_mem[widx(gold_addr[0], 0)];
        if (res_en[1])  r1[0] <= res_mem[widx(res_addr[1], 1)];
        if (gold_en[1]) g1[0] <= gold_mem[widx(gold_addr[1], 1)];
        r1[1] <= r1[0]; r1[2] <= r1[1]; g1[1] <= g1[0]; g1[2] <= g1[1];
        if (res_en[2])  r2[0] <= res_mem[widx(res_addr[2], 2)];
        if (gold_en[2]) g2[0] <= gold_mem[widx(gold_addr[2], 2)];
        r2[1] <= r2[0]; g2[1] <= g2[0];
    end
    assign res_dout  = {r2[1], r1[2], r0};
    assign gold_dout = {g2[1], g1[2], g0};

    task automatic fill();
        for (int i = 0; i < 100; i++) begin
            res_mem[i]  = $urandom;
            gold_mem[i] = res_mem[i];
        end
    endtask

    task automatic corrupt(input int i);
        gold_mem[i] = res_mem[i] ^ (32'h1 << $urandom_range(31, 0));
    endtask

    task automatic model(input int d, input bit s, output obs_t e);
        int first = -1, mc = 0;
        e = '{default: 0};
        for (int i = 0; i < NW[d]; i++)
            if (((res_mem[i] ^ gold_mem[i]) & MSK[d]) != 0) begin
                if (first < 0) first = i;
                mc++;
            end
        e.pass = mc == 0;
        e.err = 32'((s && mc > 0) ? 1 : (mc > SAT[d] ? SAT[d] : mc));
        if (first >= 0) begin
            e.fidx = 32'(first);
            e.fgot = res_mem[first];
            e.fexp = gold_mem[first];
        end
        e.done_edge = (s && mc > 0) ? first + LAT[d] + 2 : NW[d] + LAT[d] + 1;
        e.en_cnt = (s && mc > 0 && first + LAT[d] + 1 < NW[d]) ? first + LAT[d] + 1 : NW[d];
        e.max_addr = BAS[d] + STR[d] * 32'(e.en_cnt - 1);
    endtask

    task automatic run(input int d, input bit s, input int extra, input int rst_at, output obs_t o);
        int t0;
        bit fin = 0;
        o = '{default: 0};
        @(negedge clk);
        start[d] = 1; sof[d] = s; t0 = cyc;
        @(negedge clk);
        start[d] = 0;
        for (int i = 0; i < 400; i++) begin
            if (busy[d] && done[d]) o.overlap = 1;
            if (done[d]) begin fin = 1; o.done_edge = cyc - t0 - 1; break; end
            if (i == rst_at) begin rst = 1; fin = 1; break; end
            if (res_en[d]) begin
                o.en_cnt++;
                if (res_addr[d] > o.max_addr) o.max_addr = res_addr[d];
            end
            if (res_en[d] !== gold_en[d] || res_addr[d] !== gold_addr[d]) o.addr_neq = 1;
            start[d] = (i == extra);
            @(negedge clk);
        end
        start[d] = 0;
        total++;
        if (!fin) begin bad++; $display("FAIL timeout dut=%0d got no done required done", d); end
        o.pass = pass[d];
        o.err  = d == 0 ? 32'(err0) : d == 1 ? 32'(err1) : 32'(err2);
        o.fidx = fidx[d]; o.fgot = fgot[d]; o.fexp = fexp[d];
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({busy[d], done[d], pass[d], res_en[d], gold_en[d]} !== 5'b0 ||
                res_addr[d] !== 0 || gold_addr[d] !== 0 || fidx[d] !== 0 || fgot[d] !== 0 || fexp[d] !== 0) begin
                bad++; $display("FAIL reset_state dut=%0d flags=%b addr=%h idx=%h", d,
                    {busy[d], done[d], pass[d], res_en[d], gold_en[d]}, res_addr[d], fidx[d]);
            end
        end
        total++;
        if (err0 !== 0 || err1 !== 0 || err2 !== 0 || we !== '0) begin
            bad++; $display("FAIL reset_err got=%h/%h/%h we=%h required 0", err0, err1, err2, we);
        end
        rst = 0;
    endtask

    task automatic test_clean();
        obs_t o, e;
        fill(); model(0, 0, e); run(0, 0, -1, -1, o);
        total += 5;
        if (o.done_edge !== 102) begin bad++; $display("FAIL clean_done_edge got=%0d required=102", o.done_edge); end
        if (o.pass !== 1'b1 || o.err !== 0) begin bad++; $display("FAIL clean_pass got=%b/%0d required=1/0", o.pass, o.err); end
        if (o.en_cnt !== 100) begin bad++; $display("FAIL clean_en_cycles got=%0d required=100", o.en_cnt); end
        if (o.addr_neq || o.max_addr !== e.max_addr) begin bad++; $display("FAIL clean_addr got=%h required=%h", o.max_addr, e.max_addr); end
        if (o.overlap) begin bad++; $display("FAIL clean_busy_done got=overlap required=none"); end
    endtask

    task automatic test_single_err();
        obs_t o;
        fill(); res_mem[37] = 32'hFF; gold_mem[37] = 32'hFE;
        run(0, 0, -1, -1, o);
        total += 3;
        if (o.pass !== 1'b0 || o.err !== 1) begin bad++; $display("FAIL single_err got=%b/%0d required=0/1", o.pass, o.err); end
        if (o.fidx !== 37) begin bad++; $display("FAIL single_idx got=%0d required=37", o.fidx); end
        if (o.fgot !== 32'hFF || o.fexp !== 32'hFE) begin bad++; $display("FAIL single_data got=%h/%h required=ff/fe", o.fgot, o.fexp); end
    endtask

    task automatic test_multi_err();
        obs_t o;
        int idx [5] = '{5, 6, 50, 98, 99};
        fill();
        foreach (idx[i]) corrupt(idx[i]);
        run(0, 0, -1, -1, o);
        total += 3;
        if (o.err !== 5 || o.fidx !== 5) begin bad++; $display("FAIL multi_count got=%0d@%0d required=5@5", o.err, o.fidx); end
        if (o.fgot !== res_mem[5] || o.fexp !== gold_mem[5]) begin bad++; $display("FAIL multi_data got=%h/%h required=%h/%h", o.fgot, o.fexp, res_mem[5], gold_mem[5]); end
        if (o.done_edge !== 102) begin bad++; $display("FAIL multi_done_edge got=%0d required=102", o.done_edge); end
        run(1, 1, -1, -1, o);
        total += 3;
        if (o.err !== 1 || o.fidx !== 5) begin bad++; $display("FAIL sof_count got=%0d@%0d required=1@5", o.err, o.fidx); end
        if (o.done_edge !== 10) begin bad++; $display("FAIL sof_done_edge got=%0d required=10", o.done_edge); end
        if (o.en_cnt !== 9) begin bad++; $display("FAIL sof_en_cycles got=%0d required=9", o.en_cnt); end
    endtask

    task automatic test_random();
        obs_t o, e;
        for (int r = 0; r < 6; r++) begin
            int d = r % 2;
            bit s = 1'($urandom_range(1, 0));
            fill();
            repeat ($urandom_range(4, 0)) corrupt($urandom_range(99, 0));
            model(d, s, e); run(d, s, -1, -1, o);
            total += 4;
            if (o.err !== e.err || o.pass !== e.pass) begin bad++; $display("FAIL rand_count r=%0d got=%0d/%b required=%0d/%b", r, o.err, o.pass, e.err, e.pass); end
            if (o.fidx !== e.fidx || o.fgot !== e.fgot || o.fexp !== e.fexp) begin
                bad++; $display("FAIL rand_first r=%0d got=%0d %h %h required=%0d %h %h", r, o.fidx, o.fgot, o.fexp, e.fidx, e.fgot, e.fexp);
            end
            if (o.done_edge !== e.done_edge) begin bad++; $display("FAIL rand_done_edge r=%0d got=%0d required=%0d", r, o.done_edge, e.done_edge); end
            if (o.en_cnt !== e.en_cnt || o.max_addr !== e.max_addr || o.addr_neq || o.overlap) begin
                bad++; $display("FAIL rand_issue r=%0d got=%0d %h required=%0d %h", r, o.en_cnt, o.max_addr, e.en_cnt, e.max_addr);
            end
        end
    endtask

    task automatic test_mask();
        obs_t o;
        fill();
        for (int i = 0; i < 20; i++) gold_mem[i] = res_mem[i] ^ 32'($urandom_range(15, 1));
        run(2, 0, -1, -1, o);
        total += 2;
        if (o.pass !== 1'b1 || o.err !== 0) begin bad++; $display("FAIL mask_pass got=%b/%0d required=1/0", o.pass, o.err); end
        if (o.done_edge !== 23) begin bad++; $display("FAIL mask_done_edge got=%0d required=23", o.done_edge); end
    endtask

    task automatic test_saturate();
        obs_t o;
        fill();
        for (int i = 0; i < 20; i++) gold_mem[i] = res_mem[i] ^ 32'h100;
        run(2, 0, -1, -1, o);
        total += 2;
        if (o.err !== 3 || o.pass !== 1'b0) begin bad++; $display("FAIL sat_count got=%0d/%b required=3/0", o.err, o.pass); end
        if (o.fidx !== 0 || o.fexp !== gold_mem[0]) begin bad++; $display("FAIL sat_first got=%0d %h required=0 %h", o.fidx, o.fexp, gold_mem[0]); end
    endtask

    task automatic test_restart_ignored();
        obs_t o, e;
        fill(); corrupt(12); corrupt(60); corrupt(61);
        model(0, 0, e); run(0, 0, 30, -1, o);
        total += 2;
        if (o.err !== e.err || o.fidx !== e.fidx || o.fgot !== e.fgot) begin bad++; $display("FAIL restart_result got=%0d@%0d required=%0d@%0d", o.err, o.fidx, e.err, e.fidx); end
        if (o.done_edge !== 102 || o.en_cnt !== 100) begin bad++; $display("FAIL restart_timing got=%0d/%0d required=102/100", o.done_edge, o.en_cnt); end
    endtask

    task automatic test_stride();
        obs_t o;
        fill(); run(1, 0, -1, -1, o);
        total += 2;
        if (o.max_addr !== 32'h100 + 99 * 4 || o.addr_neq) begin bad++; $display("FAIL stride_last_addr got=%h required=%h", o.max_addr, 32'h100 + 99 * 4); end
        if (o.done_edge !== 104 || o.pass !== 1'b1) begin bad++; $display("FAIL stride_done got=%0d/%b required=104/1", o.done_edge, o.pass); end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        fill(); corrupt(5);
        run(0, 0, -1, 40, o);
        #1;
        total += 2;
        if ({busy[0], done[0], pass[0], res_en[0], gold_en[0]} !== 5'b0 || res_addr[0] !== 0 || gold_addr[0] !== 0) begin
            bad++; $display("FAIL async_rst_ctrl got=%b addr=%h required=0", {busy[0], done[0], pass[0], res_en[0], gold_en[0]}, res_addr[0]);
        end
        if (err0 !== 0 || fidx[0] !== 0 || fgot[0] !== 0 || fexp[0] !== 0) begin
            bad++; $display("FAIL async_rst_err got=%0d@%0d required=0@0", err0, fidx[0]);
        end
        @(negedge clk); rst = 0;
        fill(); corrupt(77); corrupt(88);
        model(0, 0, e); run(0, 0, -1, -1, o);
        total++;
        if (o.err !== e.err || o.fidx !== e.fidx || o.done_edge !== e.done_edge || o.en_cnt !== e.en_cnt) begin
            bad++; $display("FAIL after_rst_run got=%0d@%0d e%0d required=%0d@%0d e%0d", o.err, o.fidx, o.done_edge, e.err, e.fidx, e.done_edge);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_clean();
        test_single_err();
        test_multi_err();
        test_random();
        test_mask();
        test_saturate();
        test_restart_ignored();
        test_stride();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
